// File: rtl/game_timer_seq_pkg.sv
// Shared types for the round countdown sequencer: state encoding and the
// status bundle that is decoded from the state register.
package game_timer_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_RUN     = 3'd3,
    ST_PAUSED  = 3'd4,
    ST_EXPIRED = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  typedef struct packed {
    logic reconfig;
    logic running;
    logic time_up;
    logic round_done;
  } status_t;

  // Moore status decode; every flag depends on the registered state only.
  function automatic status_t decode_status(input state_e s);
    status_t st;
    st            = '0;
    st.reconfig   = (s == ST_LOAD);
    st.running    = (s == ST_RUN);
    st.time_up    = (s == ST_EXPIRED);
    st.round_done = (s == ST_DONE);
    return st;
  endfunction

endpackage

// File: rtl/game_timer_seq_if.sv
// Handshake bundle between the game controller / digit chain and the
// round countdown sequencer.
interface game_timer_seq_if #(
  parameter int unsigned NUM_DIGITS = 2
);

  logic                  Start;
  logic                  Pause;
  logic                  Answered;
  logic [NUM_DIGITS-1:0] DigitZero;
  logic                  Reconfig;
  logic                  Decrement;
  logic                  Running;
  logic                  TimeUp;
  logic                  RoundDone;
  logic [2:0]            Phase;

  // Controller / environment side.
  modport master (
    output Start, Pause, Answered, DigitZero,
    input  Reconfig, Decrement, Running, TimeUp, RoundDone, Phase
  );

  // Sequencer side.
  modport slave (
    input  Start, Pause, Answered, DigitZero,
    output Reconfig, Decrement, Running, TimeUp, RoundDone, Phase
  );

endinterface

// File: rtl/game_timer_seq_tick_prescaler.sv
// Countdown tick prescaler: counts 0..TICK_DIV-1 while enabled, wraps,
// and flags the terminal count combinationally from the count register.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned       CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]     TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, otherwise advance and wrap at the terminal count.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      if (count_q == TERM) begin
        count_d = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Terminal-count flag.
  always_comb begin
    tick = (count_q == TERM);
  end

endmodule

// File: rtl/game_timer_seq.sv
// Round countdown sequencer: round FSM, registered digit-decrement pulse and
// Moore status decode. The prescaler advances on every RUN cycle (including
// the cycle in which Pause is sampled) and is frozen in PAUSED.
module game_timer_seq
  import game_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned NUM_DIGITS = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  game_timer_seq_if.slave  bus
);

  state_e                state_q;
  state_e                state_d;
  logic                  dec_q;
  logic                  dec_d;
  logic                  tick;
  logic                  pre_clear;
  logic                  pre_enable;
  logic                  start_ok;
  logic                  all_zero;
  logic [NUM_DIGITS-1:0] zero_flags;
  status_t               status;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .Clock  (Clock),
    .Reset  (Reset),
    .clear  (pre_clear),
    .enable (pre_enable),
    .tick   (tick)
  );

  // Time-out condition: every digit reads zero.
  always_comb begin
    zero_flags = bus.DigitZero;
    all_zero   = &zero_flags;
  end

  // Next state, prescaler control and the decrement request. Start outranks
  // Answered, which outranks the tick, which outranks Pause; a tick that
  // coincides with Pause is still serviced before the move to PAUSED.
  always_comb begin
    state_d    = state_q;
    dec_d      = 1'b0;
    pre_enable = 1'b0;
    start_ok   = bus.Start && (state_q != ST_LOAD) && (state_q != ST_SETTLE);
    pre_clear  = start_ok;

    if (start_ok) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_LOAD: begin
          state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          state_d   = ST_RUN;
          pre_clear = 1'b1;
        end
        ST_RUN: begin
          pre_enable = 1'b1;
          if (bus.Answered) begin
            state_d = ST_DONE;
          end else if (tick && all_zero) begin
            state_d = ST_EXPIRED;
          end else begin
            dec_d = tick;
            if (bus.Pause) begin
              state_d = ST_PAUSED;
            end
          end
        end
        ST_PAUSED: begin
          if (bus.Answered) begin
            state_d = ST_DONE;
          end else if (!bus.Pause) begin
            state_d = ST_RUN;
          end
        end
        ST_EXPIRED, ST_DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and decrement registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
    end
  end

  // Output decode from registers only.
  always_comb begin
    status        = decode_status(state_q);
    bus.Reconfig  = status.reconfig;
    bus.Running   = status.running;
    bus.TimeUp    = status.time_up;
    bus.RoundDone = status.round_done;
    bus.Phase     = state_q;
    bus.Decrement = dec_q;
  end

endmodule
